// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in serial-out shifter with valid/ready input and gapless
//            back-to-back words; feeds the si input of a sipo deserializer.
// Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
    parameter int DW        = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          so,
    output logic          so_valid,
    output logic          so_last,
    output logic          busy
);

    localparam int              c_cw       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DW - 1);
    localparam logic [0:0]      c_idle     = 1'b0;
    localparam logic [0:0]      c_shift    = 1'b1;

    logic [0:0]      r_state,    w_state_nxt;
    logic [DW-1:0]   r_shreg,    w_shreg_nxt;
    logic [c_cw-1:0] r_cnt,      w_cnt_nxt;
    logic            r_so,       w_so_nxt;
    logic            r_so_valid, w_so_valid_nxt;
    logic            r_so_last,  w_so_last_nxt;

    logic            w_xfer;
    logic            w_load_bit;
    logic [DW-1:0]   w_load_rest;
    logic            w_shift_bit;
    logic [DW-1:0]   w_shift_rest;

    // The first bit goes straight to so on load; shreg keeps only the remainder.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_bit   = din[DW-1];
            assign w_load_rest  = {din[DW-2:0], 1'b0};
            assign w_shift_bit  = r_shreg[DW-1];
            assign w_shift_rest = {r_shreg[DW-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_load_bit   = din[0];
            assign w_load_rest  = {1'b0, din[DW-1:1]};
            assign w_shift_bit  = r_shreg[0];
            assign w_shift_rest = {1'b0, r_shreg[DW-1:1]};
        end
    endgenerate

    assign w_xfer = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_idle;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_so_last  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_so       <= w_so_nxt;
            r_so_valid <= w_so_valid_nxt;
            r_so_last  <= w_so_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_so_nxt    = r_so;
        case (r_state)
            c_idle: begin
                if (w_xfer) begin
                    w_state_nxt = c_shift;
                    w_shreg_nxt = w_load_rest;
                    w_cnt_nxt   = '0;
                    w_so_nxt    = w_load_bit;
                end
            end
            c_shift: begin
                if (r_cnt == c_cnt_last) begin
                    if (w_xfer) begin
                        w_shreg_nxt = w_load_rest;
                        w_cnt_nxt   = '0;
                        w_so_nxt    = w_load_bit;
                    end else begin
                        w_state_nxt = c_idle;
                        w_shreg_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_so_nxt    = 1'b0;
                    end
                end else begin
                    w_shreg_nxt = w_shift_rest;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_so_nxt    = w_shift_bit;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_shreg_nxt = '0;
                w_cnt_nxt   = '0;
                w_so_nxt    = 1'b0;
            end
        endcase
        w_so_valid_nxt = (w_state_nxt == c_shift);
        w_so_last_nxt  = (w_state_nxt == c_shift) && (w_cnt_nxt == c_cnt_last);
    end

    always_comb begin
        din_ready = !rst && ((r_state == c_idle) || (r_cnt == c_cnt_last));
        busy      = (r_state == c_shift);
        so        = r_so;
        so_valid  = r_so_valid;
        so_last   = r_so_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// Bench for piso_serializer: DW=4 MSB-first instance against a bit-queue model,
// plus a DW=8 LSB-first instance feeding a behavioural sipo.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din4;
    logic       v4;
    logic       rdy4, so4, sov4, sol4, busy4;
    logic [7:0] din8;
    logic       v8;
    logic       rdy8, so8, sov8, sol8, busy8;

    always #5 clk = ~clk;

    piso_serializer #(.DW(4), .MSB_FIRST(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .din_ready(rdy4),
        .so(so4), .so_valid(sov4), .so_last(sol4), .busy(busy4)
    );

    piso_serializer #(.DW(8), .MSB_FIRST(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .din_valid(v8), .din_ready(rdy8),
        .so(so8), .so_valid(sov8), .so_last(sol8), .busy(busy8)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          q[$];          // bits still to appear on so, front = current bit
    int          n_acc_model;
    int          n_last_seen;
    logic [31:0] bits_seen;
    int          nbits;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic check_model();
        check_eq("so",        {31'd0, so4},   (q.size() != 0) ? {31'd0, q[0]} : 32'd0);
        check_eq("so_valid",  {31'd0, sov4},  (q.size() != 0) ? 32'd1 : 32'd0);
        check_eq("so_last",   {31'd0, sol4},  (q.size() == 1) ? 32'd1 : 32'd0);
        check_eq("busy",      {31'd0, busy4}, (q.size() != 0) ? 32'd1 : 32'd0);
        check_eq("din_ready", {31'd0, rdy4},  (q.size() <= 1) ? 32'd1 : 32'd0);
    endtask

    // Called just after a falling edge: drive, advance one rising edge, check.
    task automatic cycle(input logic v, input logic [3:0] d);
        bit ready;
        v4   = v;
        din4 = d;
        @(posedge clk);
        ready = (q.size() <= 1);
        if (q.size() != 0) q.delete(0);
        if (v && ready) begin
            n_acc_model++;
            for (int k = 0; k < 4; k++) q.push_back(d[3-k]);
        end
        @(negedge clk);
        if (sol4) n_last_seen++;
        if (sov4) begin
            bits_seen = {bits_seen[30:0], so4};
            nbits++;
        end
        check_model();
    endtask

    task automatic clear_seen();
        bits_seen = '0;
        nbits     = 0;
    endtask

    task automatic send8(input logic [7:0] w);
        logic [7:0] sipo;
        int         cnt;
        sipo = '0;
        cnt  = 0;
        check_eq("rdy8_idle", {31'd0, rdy8}, 32'd1);
        v8   = 1'b1;
        din8 = w;
        @(posedge clk);
        @(negedge clk);
        v8 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (sov8) begin
                sipo = {sipo[6:0], so8};
                cnt++;
            end
            @(negedge clk);
        end
        check_eq("sipo_word", {24'd0, sipo}, {24'd0, rev8(w)});
        check_eq("sipo_bits", cnt, 32'd8);
    endtask

    initial begin
        rst  = 1'b1;
        v4   = 1'b0; din4 = '0;
        v8   = 1'b0; din8 = '0;
        n_acc_model = 0;
        n_last_seen = 0;
        clear_seen();

        // reset state
        #12;
        check_eq("rst_so",    {31'd0, so4},   32'd0);
        check_eq("rst_sov",   {31'd0, sov4},  32'd0);
        check_eq("rst_busy",  {31'd0, busy4}, 32'd0);
        check_eq("rst_ready", {31'd0, rdy4},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rel_ready4", {31'd0, rdy4}, 32'd1);
        check_eq("rel_ready8", {31'd0, rdy8}, 32'd1);
        @(negedge clk);

        // back-to-back 1010, 0101 with din_valid held
        clear_seen();
        cycle(1'b1, 4'b1010);
        repeat (4) cycle(1'b1, 4'b0101);
        repeat (4) cycle(1'b0, 4'b0000);
        check_eq("b2b_bits",  bits_seen[7:0], 8'b1010_0101);
        check_eq("b2b_count", nbits, 32'd8);

        // single word then idle
        clear_seen();
        cycle(1'b1, 4'b1100);
        repeat (5) cycle(1'b0, 4'b1111);
        check_eq("single_bits",  bits_seen[3:0], 4'b1100);
        check_eq("single_count", nbits, 32'd4);

        // random traffic with din changing while busy
        n_acc_model = 0;
        n_last_seen = 0;
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
        repeat (5) cycle(1'b0, 4'b0000);
        check_eq("accepted_words", n_last_seen, n_acc_model);

        // reset after two bits of 1011, then a fresh 0110
        clear_seen();
        cycle(1'b1, 4'b1011);
        cycle(1'b0, 4'b0000);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_so",    {31'd0, so4},   32'd0);
        check_eq("mid_sov",   {31'd0, sov4},  32'd0);
        check_eq("mid_last",  {31'd0, sol4},  32'd0);
        check_eq("mid_busy",  {31'd0, busy4}, 32'd0);
        check_eq("mid_ready", {31'd0, rdy4},  32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle(1'b0, 4'b0000);
        clear_seen();
        cycle(1'b1, 4'b0110);
        repeat (4) cycle(1'b0, 4'b0000);
        check_eq("post_rst_bits",  bits_seen[3:0], 4'b0110);
        check_eq("post_rst_count", nbits, 32'd4);

        // LSB-first DW=8 into a sipo
        send8(8'hA5);
        send8(8'h1E);
        send8(8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
